// File: rtl/code_pf_pkg.sv
// Shared types and constants for the code-cache line prefetcher.
package code_pf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } pf_state_e;

    localparam int LINE_WORDS = 8;
    localparam int LINE_BYTES = 32;
    localparam int LINE_OFF_W = $clog2(LINE_BYTES);

    // Code lives in 0x100-0x3FF: any address with bit 9 or bit 8 set.
    function automatic logic in_code_region(input logic [1:0] addr_9_8);
        return addr_9_8[1] | addr_9_8[0];
    endfunction

endpackage

// File: rtl/code_prefetcher.sv
// Line-fill engine: on a code-cache miss, reads the 8-word line holding the
// missed address from SDRAM (up to MAX_OUT reads in flight) and streams the
// returned words, in ascending order, into the cache fill port.
//
// Handshakes: an SDRAM request transfers in any cycle where sd_in_valid is
// high and sd_busy is low; sd_addr is held while the request is blocked.
// SDRAM returns (sd_out_valid) and cache fills (data_in_valid) are one-cycle
// strobes with no back-pressure; returns arrive in request order.
module code_prefetcher #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = code_pf_pkg::LINE_WORDS,
    parameter int MAX_OUT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              busy,
    output logic              sd_in_valid,
    output logic              sd_rw,
    output logic [ADDR_W-1:0] sd_addr,
    input  logic              sd_busy,
    input  logic              sd_out_valid,
    input  logic [DATA_W-1:0] sd_data,
    output logic              data_in_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);
    import code_pf_pkg::*;

    localparam logic [3:0] LINE_CNT  = 4'(LINE_WORDS);
    localparam logic [3:0] LAST_IDX  = 4'(LINE_WORDS - 1);
    localparam logic [1:0] MAX_OUT_C = 2'(MAX_OUT);

    pf_state_e         state_q, state_d;
    logic [3:0]        issued_q, issued_d;
    logic [3:0]        returned_q, returned_d;
    logic [1:0]        outs_q, outs_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fill_q, fill_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_fire;
    logic              ret_fire;

    // Byte-offset bits of the miss address are irrelevant: the line base is aligned.
    logic unused_offset;
    assign unused_offset = ^miss_addr[LINE_OFF_W-1:0];

    assign sd_in_valid = (state_q == FILL) && (issued_q < LINE_CNT) && (outs_q < MAX_OUT_C);
    assign sd_addr     = base_q + ADDR_W'({issued_q, 2'b00});
    assign sd_rw       = 1'b0;
    assign req_fire    = sd_in_valid && !sd_busy;
    // A return with nothing outstanding is stray: dropped and flagged.
    assign ret_fire    = sd_out_valid && (outs_q != 2'd0);

    assign busy          = (state_q != IDLE);
    assign data_in_valid = fill_q;
    assign data_in       = data_q;
    assign done          = done_q;
    assign err           = err_q;
    assign dbg_state     = state_q;

    // Next-state, counter tracking and fill-word capture.
    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        outs_d     = outs_q;
        base_d     = base_q;
        data_d     = data_q;
        fill_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        if (req_fire) begin
            issued_d = issued_q + 4'd1;
        end
        if (ret_fire) begin
            returned_d = returned_q + 4'd1;
            data_d     = sd_data;
            fill_d     = 1'b1;
            done_d     = (returned_q == LAST_IDX);
        end
        if (sd_out_valid && (outs_q == 2'd0)) begin
            err_d = 1'b1;
        end
        // Accept and return together leave the in-flight count unchanged.
        outs_d = outs_q + {1'b0, req_fire} - {1'b0, ret_fire};

        case (state_q)
            IDLE: begin
                if (miss_req && in_code_region(miss_addr[9:8])) begin
                    state_d    = FILL;
                    base_d     = {miss_addr[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
                    issued_d   = 4'd0;
                    returned_d = 4'd0;
                    outs_d     = 2'd0;
                end
            end
            FILL: begin
                if (req_fire && (issued_q == LAST_IDX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // done_q marks the cycle the last word is on the fill port.
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            issued_q   <= 4'd0;
            returned_q <= 4'd0;
            outs_q     <= 2'd0;
            base_q     <= '0;
            data_q     <= '0;
            fill_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            outs_q     <= outs_d;
            base_q     <= base_d;
            data_q     <= data_d;
            fill_q     <= fill_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_code_prefetcher.sv
// Bench for code_prefetcher: SDRAM model with 2-cycle read latency, a
// reference model of the fill protocol, and a scoreboard of fill words.
module tb_code_prefetcher;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_init;
  logic rst_model;
  logic rst;
  assign rst = rst_init | rst_model;

  // ---------------- DUT ----------------
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              busy, sd_in_valid, sd_rw;
  logic [ADDR_W-1:0] sd_addr;
  logic              sd_busy;
  logic              sd_out_valid, sd_out_valid_m, inject;
  logic [DATA_W-1:0] sd_data, sd_data_m;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_in;
  logic              done, err;
  logic [1:0]        dbg_state;

  assign sd_out_valid = sd_out_valid_m | inject;
  assign sd_data      = inject ? 32'hDEAD_BEEF : sd_data_m;

  code_prefetcher #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(8), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy),
    .sd_in_valid(sd_in_valid), .sd_rw(sd_rw), .sd_addr(sd_addr),
    .sd_busy(sd_busy), .sd_out_valid(sd_out_valid), .sd_data(sd_data),
    .data_in_valid(data_in_valid), .data_in(data_in),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] pend_data[$];
  int                pend_due[$];

  int                cyc = 0;
  int                ret_total = 0;
  int                rst_at = 0;
  logic              busy_mode = 1'b0;
  logic              mon_en = 1'b0;

  logic              line_active = 1'b0;
  logic [ADDR_W-1:0] base_m = '0;
  int                issued_m = 0;
  int                out_m = 0;
  int                fills_m = 0;
  logic              err_m = 1'b0;
  int                req_seen = 0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;

  logic              acc, ret_ok, exp_valid;
  logic [DATA_W-1:0] exp_w;
  logic [ADDR_W-1:0] exp_addr;

  function automatic logic in_region(input logic [ADDR_W-1:0] a);
    return a[9] | a[8];
  endfunction

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {9'h1A5, a};
  endfunction

  task automatic chk(input string tag, input logic ok,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- SDRAM model: in-order returns, 2-cycle latency ----------------
  initial begin
    sd_busy = 1'b0;
    sd_out_valid_m = 1'b0;
    sd_data_m = '0;
    rst_model = 1'b0;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    sd_busy = busy_mode ? ~sd_busy : 1'b0;
    sd_out_valid_m = 1'b0;
    rst_model = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      sd_out_valid_m = 1'b1;
      sd_data_m = pend_data.pop_front();
      void'(pend_due.pop_front());
      ret_total++;
      if (rst_at != 0 && ret_total == rst_at) begin
        rst_model = 1'b1;
        pend_data.delete();
        pend_due.delete();
      end
    end
  end

  // ---------------- protocol monitor and scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      exp_valid = line_active && (issued_m < 8) && (out_m < MAX_OUT);
      exp_addr  = base_m + ADDR_W'(4 * issued_m);
      chk("busy", busy === line_active, busy, line_active);
      chk("sd_in_valid", sd_in_valid === exp_valid, sd_in_valid, exp_valid);
      chk("sd_rw", sd_rw === 1'b0, sd_rw, 1'b0);
      chk("err", err === err_m, err, err_m);
      if (sd_in_valid) chk("sd_addr", sd_addr === exp_addr, sd_addr, exp_addr);
      if (data_in_valid) begin
        chk("fill_expected", exp_q.size() > 0, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          chk("data_in", data_in === exp_w, data_in, exp_w);
        end
        chk("done_with_8th", done === (fills_m == 7), done, (fills_m == 7));
        fills_m++;
      end else begin
        chk("done_without_fill", done === 1'b0, done, 1'b0);
      end

      if (rst) begin
        line_active = 1'b0;
        issued_m = 0;
        out_m = 0;
        fills_m = 0;
        err_m = 1'b0;
        exp_q.delete();
        pend_data.delete();
        pend_due.delete();
      end else begin
        acc    = sd_in_valid && !sd_busy;
        ret_ok = sd_out_valid && (out_m > 0);
        if (sd_out_valid && out_m == 0) err_m = 1'b1;
        if (acc) begin
          req_seen++;
          if (issued_m == 0) first_addr = sd_addr;
          last_addr = sd_addr;
          exp_q.push_back(word_of(exp_addr));
          pend_data.push_back(word_of(sd_addr));
          pend_due.push_back(cyc + 2);
          issued_m++;
        end
        out_m = out_m + (acc ? 1 : 0) - (ret_ok ? 1 : 0);
        chk("outstanding_cap", out_m <= MAX_OUT, out_m, MAX_OUT);
        if (line_active && data_in_valid && fills_m == 8) begin
          chk("line_drained", (exp_q.size() == 0) && (out_m == 0), out_m, 0);
          line_active = 1'b0;
        end else if (!line_active && miss_req && in_region(miss_addr)) begin
          line_active = 1'b1;
          base_m = {miss_addr[ADDR_W-1:5], 5'b0};
          issued_m = 0;
          fills_m = 0;
          out_m = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_miss(input logic [ADDR_W-1:0] addr);
    @(posedge clk); #1;
    miss_req = 1'b1;
    miss_addr = addr;
    @(posedge clk); #1;
    miss_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!line_active) break;
    end
    chk(tag, line_active === 1'b0, line_active, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy === 1'b0, busy, 1'b0);
    chk({tag, "_sd_in_valid"}, sd_in_valid === 1'b0, sd_in_valid, 1'b0);
    chk({tag, "_sd_addr"}, sd_addr === 23'h0, sd_addr, 23'h0);
    chk({tag, "_data_in_valid"}, data_in_valid === 1'b0, data_in_valid, 1'b0);
    chk({tag, "_data_in"}, data_in === 32'h0, data_in, 32'h0);
    chk({tag, "_done"}, done === 1'b0, done, 1'b0);
    chk({tag, "_err"}, err === 1'b0, err, 1'b0);
    chk({tag, "_state"}, dbg_state === 2'd0, dbg_state, 2'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen_before;
    rst_init = 1'b1;
    miss_req = 1'b0;
    miss_addr = '0;
    inject = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_init = 1'b0;
    mon_en = 1'b1;

    // Line at 0x100, no back-pressure.
    do_miss(23'h100);
    wait_idle("line_100_timeout");
    chk("line_100_first", first_addr === 23'h100, first_addr, 23'h100);
    chk("line_100_last", last_addr === 23'h11C, last_addr, 23'h11C);
    chk("line_100_fills", fills_m == 8, fills_m, 8);

    // Unaligned miss inside a line.
    do_miss(23'h1B4);
    wait_idle("line_1a0_timeout");
    chk("line_1a0_first", first_addr === 23'h1A0, first_addr, 23'h1A0);
    chk("line_1a0_last", last_addr === 23'h1BC, last_addr, 23'h1BC);

    // Toggling sd_busy during the fill.
    busy_mode = 1'b1;
    seen_before = req_seen;
    do_miss(23'h2C8);
    wait_idle("line_2c0_timeout");
    busy_mode = 1'b0;
    chk("line_2c0_first", first_addr === 23'h2C0, first_addr, 23'h2C0);
    chk("line_2c0_last", last_addr === 23'h2DC, last_addr, 23'h2DC);
    chk("line_2c0_reqs", (req_seen - seen_before) == 8, req_seen - seen_before, 8);
    chk("line_2c0_fills", fills_m == 8, fills_m, 8);

    // Miss outside the code region is ignored.
    seen_before = req_seen;
    do_miss(23'h040);
    repeat (6) @(negedge clk);
    chk("outside_busy", busy === 1'b0, busy, 1'b0);
    chk("outside_reqs", req_seen == seen_before, req_seen, seen_before);

    // Second miss during a fill is ignored.
    seen_before = req_seen;
    do_miss(23'h200);
    repeat (3) @(posedge clk);
    #1;
    miss_req = 1'b1;
    miss_addr = 23'h300;
    @(posedge clk); #1;
    miss_req = 1'b0;
    wait_idle("line_200_timeout");
    repeat (4) @(negedge clk);
    chk("line_200_first", first_addr === 23'h200, first_addr, 23'h200);
    chk("line_200_last", last_addr === 23'h21C, last_addr, 23'h21C);
    chk("line_200_reqs", (req_seen - seen_before) == 8, req_seen - seen_before, 8);
    chk("line_200_idle_after", busy === 1'b0, busy, 1'b0);

    // Stray return while idle sets the sticky error.
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    repeat (4) @(negedge clk);
    chk("err_sticky", err === 1'b1, err, 1'b1);
    chk("err_no_fill", data_in_valid === 1'b0, data_in_valid, 1'b0);

    // Reset on the 4th return of a fill, then a fresh line.
    rst_at = ret_total + 4;
    do_miss(23'h300);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rst) break;
    end
    chk("mid_reset_seen", rst === 1'b1, rst, 1'b1);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    do_miss(23'h3E0);
    wait_idle("line_3e0_timeout");
    chk("line_3e0_first", first_addr === 23'h3E0, first_addr, 23'h3E0);
    chk("line_3e0_last", last_addr === 23'h3FC, last_addr, 23'h3FC);
    chk("line_3e0_fills", fills_m == 8, fills_m, 8);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
